coffee_brew_ctrl: RTL

Parametrised beverage-brewing controller: the next-generation coffee machine state machine with a configurable recipe count, programmable phase durations, sugar option, fault codes and a served-cup counter. It sits between the front-panel and sensor inputs and the actuator drivers (heater, water valve, powder doser, sugar doser, mixer). All actuator outputs are Moore decodes of registered state.

---
 rtl/coffee_brew_ctrl_if.sv | 45 ++++
 rtl/coffee_brew_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/coffee_brew_ctrl_if.sv
// rtl/coffee_brew_ctrl_if.sv - front-panel/sensor/actuator bundle for coffee_brew_ctrl
//
// Purpose: groups every non-clock/reset signal of the brew controller.
// Ports (signals):
//   panel/sensor -> ctrl : SR, SP, SN (levels OK), A (cup present), VL (request),
//                          SEL (recipe), SUG (sugar), CLR (fault clear)
//   ctrl -> drivers/panel: READY, AQ (heater), P (water), PP (powder), SG (sugar),
//                          M (mixer), DONE, FAULT, ERR (fault code), STATE (debug),
//                          CUPS (served-cup counter)
// Modports: master = panel/sensor side, slave = controller side.

interface coffee_brew_ctrl_if #(
  parameter int SEL_W = 2,
  parameter int CUP_W = 8
);
  logic             SR;
  logic             SP;
  logic             SN;
  logic             A;
  logic             VL;
  logic [SEL_W-1:0] SEL;
  logic             SUG;
  logic             CLR;
  logic             READY;
  logic             AQ;
  logic             P;
  logic             PP;
  logic             SG;
  logic             M;
  logic             DONE;
  logic             FAULT;
  logic [2:0]       ERR;
  logic [3:0]       STATE;
  logic [CUP_W-1:0] CUPS;

  modport master (
    output SR, SP, SN, A, VL, SEL, SUG, CLR,
    input  READY, AQ, P, PP, SG, M, DONE, FAULT, ERR, STATE, CUPS
  );

  modport slave (
    input  SR, SP, SN, A, VL, SEL, SUG, CLR,
    output READY, AQ, P, PP, SG, M, DONE, FAULT, ERR, STATE, CUPS
  );
endinterface

// File: rtl/coffee_brew_ctrl.sv
// rtl/coffee_brew_ctrl.sv - parametrised beverage-brewing controller FSM
//
// Purpose: sequences CHECK -> HEAT -> POUR -> POWDER -> [SUGAR] -> MIX -> DONE for
// one accepted request, aborting to FAULT with a code on cup removal or a sensor drop.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - synchronous active-low reset
//   bus   - coffee_brew_ctrl_if.slave (sensors/requests in, actuators/status out)
// All outputs are Moore decodes of registered state.

module coffee_brew_ctrl #(
  parameter int N_DRINKS = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 8,
  parameter int T_HEAT   = 20,
  parameter int T_POUR   = 10,
  parameter int T_POWDER = 4,
  parameter int T_SUGAR  = 3,
  parameter int T_MIX    = 5,
  parameter int CUP_W    = 8
) (
  input logic               CLK,
  input logic               RST_N,
  coffee_brew_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_HEAT   = 4'd2,
    S_POUR   = 4'd3,
    S_POWDER = 4'd4,
    S_SUGAR  = 4'd5,
    S_MIX    = 4'd6,
    S_DONE   = 4'd7,
    S_FAULT  = 4'd8
  } state_e;

  // Timers load duration-1 so a phase lasts exactly its duration.
  localparam logic [CNT_W-1:0] HEAT_LD  = CNT_W'(T_HEAT - 1);
  localparam logic [CNT_W-1:0] POUR_LD  = CNT_W'(T_POUR - 1);
  localparam logic [CNT_W-1:0] SUGAR_LD = CNT_W'(T_SUGAR - 1);
  localparam logic [CNT_W-1:0] MIX_LD   = CNT_W'(T_MIX - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [2:0]         err_q, err_d;
  logic [CUP_W-1:0]   cups_q, cups_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sug_q, sug_d;

  logic [CNT_W-1:0]   powder_ld;
  logic [31:0]        sel_ext;
  logic               timer_zero;
  logic [CNT_W-1:0]   timer_dec;
  logic               abort;
  logic [2:0]         abort_code;

  assign powder_ld  = CNT_W'(T_POWDER * (int'(sel_q) + 1) - 1);
  assign sel_ext    = 32'(bus.SEL);
  assign timer_zero = (timer_q == '0);
  assign timer_dec  = timer_q - CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      err_q   <= '0;
      cups_q  <= '0;
      sel_q   <= '0;
      sug_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      cups_q  <= cups_d;
      sel_q   <= sel_d;
      sug_q   <= sug_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    err_d      = err_q;
    cups_d     = cups_q;
    sel_d      = sel_q;
    sug_d      = sug_q;
    abort      = 1'b0;
    abort_code = 3'd0;

    // Cup removal outranks any sensor drop in the timed phases.
    if (state_q inside {S_HEAT, S_POUR, S_POWDER, S_SUGAR, S_MIX}) begin
      if (!bus.A) begin
        abort = 1'b1; abort_code = 3'd5;
      end else if (state_q == S_POUR && !bus.SR) begin
        abort = 1'b1; abort_code = 3'd1;
      end else if (state_q == S_POWDER && !bus.SP) begin
        abort = 1'b1; abort_code = 3'd2;
      end else if (state_q == S_SUGAR && !bus.SN) begin
        abort = 1'b1; abort_code = 3'd3;
      end
    end

    if (abort) begin
      state_d = S_FAULT;
      err_d   = abort_code;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.VL && bus.A) begin
            sel_d = bus.SEL;
            sug_d = bus.SUG;
            if (sel_ext >= 32'(N_DRINKS)) begin
              state_d = S_FAULT;
              err_d   = 3'd4;
            end else begin
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (!bus.SR) begin
            state_d = S_FAULT; err_d = 3'd1;
          end else if (!bus.SP) begin
            state_d = S_FAULT; err_d = 3'd2;
          end else if (sug_q && !bus.SN) begin
            state_d = S_FAULT; err_d = 3'd3;
          end else begin
            state_d = S_HEAT; timer_d = HEAT_LD;
          end
        end
        S_HEAT: begin
          if (timer_zero) begin
            state_d = S_POUR; timer_d = POUR_LD;
          end else timer_d = timer_dec;
        end
        S_POUR: begin
          if (timer_zero) begin
            state_d = S_POWDER; timer_d = powder_ld;
          end else timer_d = timer_dec;
        end
        S_POWDER: begin
          if (timer_zero) begin
            if (sug_q) begin
              state_d = S_SUGAR; timer_d = SUGAR_LD;
            end else begin
              state_d = S_MIX; timer_d = MIX_LD;
            end
          end else timer_d = timer_dec;
        end
        S_SUGAR: begin
          if (timer_zero) begin
            state_d = S_MIX; timer_d = MIX_LD;
          end else timer_d = timer_dec;
        end
        S_MIX: begin
          if (timer_zero) state_d = S_DONE;
          else timer_d = timer_dec;
        end
        S_DONE: begin
          if (!bus.A) state_d = S_IDLE;
        end
        S_FAULT: begin
          if (bus.CLR) begin
            state_d = S_IDLE; err_d = 3'd0;
          end
        end
        default: begin
          state_d = S_IDLE; timer_d = '0;
        end
      endcase
    end

    // Count a cup only on the transition into DONE.
    if (state_d == S_DONE && state_q != S_DONE) cups_d = cups_q + CUP_W'(1);
  end

  assign bus.READY = (state_q == S_IDLE);
  assign bus.AQ    = (state_q == S_HEAT);
  assign bus.P     = (state_q == S_POUR);
  assign bus.PP    = (state_q == S_POWDER);
  assign bus.SG    = (state_q == S_SUGAR);
  assign bus.M     = (state_q == S_MIX);
  assign bus.DONE  = (state_q == S_DONE);
  assign bus.FAULT = (state_q == S_FAULT);
  assign bus.ERR   = err_q;
  assign bus.STATE = state_q;
  assign bus.CUPS  = cups_q;

endmodule
